// File: rtl/wb2apb_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb2apb_master : pipelined Wishbone slave to APB master, one transfer in flight
// Revision 1.0
// ---------------------------------------------------------------------------
module wb2apb_master #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  input  logic                        i_wb_we,
  input  logic [AW-1:0]               i_wb_addr,
  input  logic [DW-1:0]               i_wb_data,
  input  logic [DW/8-1:0]             i_wb_sel,
  output logic                        o_wb_stall,
  output logic                        o_wb_ack,
  output logic [DW-1:0]               o_wb_data,
  output logic                        o_wb_err,
  output logic                        o_psel,
  output logic                        o_penable,
  output logic                        o_pwrite,
  output logic [AW+$clog2(DW/8)-1:0]  o_paddr,
  output logic [DW-1:0]               o_pwdata,
  output logic [DW/8-1:0]             o_pstrb,
  input  logic                        i_pready,
  input  logic [DW-1:0]               i_prdata,
  input  logic                        i_pslverr
);

  localparam int SW  = DW / 8;
  localparam int BW  = $clog2(SW);
  localparam int PAW = AW + BW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             stall_q, stall_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             pwrite_q, pwrite_d;
  logic [PAW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]    pwdata_q, pwdata_d;
  logic [SW-1:0]    pstrb_q, pstrb_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             live_q, live_d;

  logic             w_accept;
  logic             w_live;

  assign w_accept = i_wb_cyc && i_wb_stb && !stall_q;
  // A dropped cycle cancels the response even if it drops in the completion cycle.
  assign w_live   = live_q && i_wb_cyc;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    stall_d   = stall_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    live_d    = w_live;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          pwrite_d  = i_wb_we;
          paddr_d   = PAW'(i_wb_addr) << BW;
          pwdata_d  = i_wb_data;
          pstrb_d   = i_wb_we ? i_wb_sel : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          stall_d   = 1'b1;
          live_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (i_pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          stall_d   = 1'b0;
          ack_d     = w_live && !i_pslverr;
          err_d     = w_live && i_pslverr;
          if (!pwrite_q) begin
            rdata_d = i_prdata;
          end
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        stall_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      stall_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      stall_q   <= stall_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      live_q    <= live_d;
    end
  end

  assign o_psel     = psel_q;
  assign o_penable  = penable_q;
  assign o_wb_stall = stall_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_pwrite   = pwrite_q;
  assign o_paddr    = paddr_q;
  assign o_pwdata   = pwdata_q;
  assign o_pstrb    = pstrb_q;
  assign o_wb_data  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb2apb_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb2apb_master : directed scenarios with a response scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wb2apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] rdata;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ack;
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  wb2apb_master #(.AW(8), .DW(32)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata), .o_wb_err(err),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
    .o_pwdata(pwdata), .o_pstrb(pstrb),
    .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Response monitor: every ACK/ERR must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (penable && !psel) begin
        errors++;
        $display("FAIL penable_without_psel: penable=%0b psel=%0b", penable, psel);
      end
      if (ack || err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_response: ack=%0b err=%0b, expected none", ack, err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (ack !== e.ack || err !== e.err) begin
            errors++;
            $display("FAIL response_kind: ack=%0b err=%0b, expected ack=%0b err=%0b",
                     ack, err, e.ack, e.err);
          end
          if (e.rd && rdata !== e.data) begin
            errors++;
            $display("FAIL read_data: got %h, expected %h", rdata, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 0; stb = 0; we = 0; addr = 0; wdata = 0; sel = 0;
    pready = 0; prdata = 0; pslverr = 0;
    repeat (2) tick();
    checks++;
    if ({psel, penable, stall, ack, err, pwrite} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: psel/pen/stall/ack/err/pwrite=%b, expected 000000",
               {psel, penable, stall, ack, err, pwrite});
    end
    checks++;
    if (paddr !== 10'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h rdata=%h, expected zeros",
               paddr, pwdata, pstrb, rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    issue(1'b1, 8'h05, 32'hDEADBEEF, 4'hF);
    sb.push_back('{ack: 1'b1, err: 1'b0, rd: 1'b0, data: 32'h0});
    tick(); // c1
    stb = 1'b0;
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL wr_c1: psel=%0b pen=%0b stall=%0b, expected 1 0 1", psel, penable, stall);
    end
    checks++;
    if (paddr !== 10'h014 || pstrb !== 4'hF || pwrite !== 1'b1 || pwdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_fields: paddr=%h pstrb=%h pwrite=%0b pwdata=%h, expected 014 f 1 deadbeef",
               paddr, pstrb, pwrite, pwdata);
    end
    tick(); // c2
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++;
      $display("FAIL wr_c2: psel=%0b pen=%0b, expected 1 1", psel, penable);
    end
    pready = 1'b1;
    tick(); // c3
    pready = 1'b0;
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL wr_c3: ack=%0b err=%0b psel=%0b pen=%0b stall=%0b, expected 1 0 0 0 0",
               ack, err, psel, penable, stall);
    end
    cyc = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL wr_done: ack=%0b pending=%0d, expected 0 0", ack, sb.size());
    end
  endtask

  task automatic test_read_wait();
    issue(1'b0, 8'h3C, 32'h0, 4'hF);
    sb.push_back('{ack: 1'b1, err: 1'b0, rd: 1'b1, data: 32'h12345678});
    tick(); // c1
    stb = 1'b0;
    checks++;
    if (pstrb !== 4'h0 || pwrite !== 1'b0 || paddr !== 10'h0F0) begin
      errors++;
      $display("FAIL rd_fields: pstrb=%h pwrite=%0b paddr=%h, expected 0 0 0f0", pstrb, pwrite, paddr);
    end
    prdata = 32'hBAD0BAD0;
    pslverr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (penable !== 1'b1 || psel !== 1'b1 || paddr !== 10'h0F0 || ack !== 1'b0) begin
        errors++;
        $display("FAIL rd_wait%0d: pen=%0b psel=%0b paddr=%h ack=%0b, expected 1 1 0f0 0",
                 i, penable, psel, paddr, ack);
      end
      if (i == 3) begin
        pready = 1'b1; prdata = 32'h12345678; pslverr = 1'b0;
      end
    end
    tick();
    pready = 1'b0; prdata = 32'h0;
    checks++;
    if (ack !== 1'b1 || rdata !== 32'h12345678 || penable !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: ack=%0b rdata=%h pen=%0b, expected 1 12345678 0", ack, rdata, penable);
    end
    cyc = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    issue(1'b1, 8'hA0, 32'hCAFEF00D, 4'h5);
    sb.push_back('{ack: 1'b0, err: 1'b1, rd: 1'b0, data: 32'h0});
    tick();
    stb = 1'b0;
    checks++;
    if (pstrb !== 4'h5 || paddr !== 10'h280) begin
      errors++;
      $display("FAIL err_fields: pstrb=%h paddr=%h, expected 5 280", pstrb, paddr);
    end
    tick();
    pready = 1'b1; pslverr = 1'b1;
    tick();
    pready = 1'b0; pslverr = 1'b0;
    checks++;
    if (err !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%0b ack=%0b, expected 1 0", err, ack);
    end
    cyc = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL err_done: err=%0b pending=%0d, expected 0 0", err, sb.size());
    end
  endtask

  task automatic test_cyc_drop();
    issue(1'b0, 8'h11, 32'h0, 4'hF);
    tick(); // c1
    stb = 1'b0;
    tick(); // c2, ACCESS begins
    cyc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1 || stall !== 1'b1) begin
        errors++;
        $display("FAIL drop_wait%0d: psel=%0b pen=%0b stall=%0b, expected 1 1 1",
                 i, psel, penable, stall);
      end
      if (i == 4) begin
        pready = 1'b1; prdata = 32'h55AA55AA;
      end
    end
    tick();
    pready = 1'b0;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || stall !== 1'b0 || psel !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: ack=%0b err=%0b stall=%0b psel=%0b, expected 0 0 0 0",
               ack, err, stall, psel);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1;
    issue(1'b0, 8'h20, 32'h0, 4'hF);
    sb.push_back('{ack: 1'b1, err: 1'b0, rd: 1'b1, data: 32'hA1A1A1A1});
    tick(); // c1
    checks++;
    if (psel !== 1'b1 || paddr !== 10'h080) begin
      errors++;
      $display("FAIL b2b_first: psel=%0b paddr=%h, expected 1 080", psel, paddr);
    end
    addr = 8'h21;
    sb.push_back('{ack: 1'b1, err: 1'b0, rd: 1'b1, data: 32'hB2B2B2B2});
    tick(); // c2
    prdata = 32'hA1A1A1A1;
    tick(); // c3
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || stall !== 1'b0 || ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: psel=%0b pen=%0b stall=%0b ack=%0b, expected 0 0 0 1",
               psel, penable, stall, ack);
    end
    tick(); // c4
    stb = 1'b0;
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 10'h084) begin
      errors++;
      $display("FAIL b2b_second: psel=%0b pen=%0b paddr=%h, expected 1 0 084", psel, penable, paddr);
    end
    tick(); // c5
    prdata = 32'hB2B2B2B2;
    tick(); // c6
    pready = 1'b0;
    checks++;
    if (ack !== 1'b1 || rdata !== 32'hB2B2B2B2) begin
      errors++;
      $display("FAIL b2b_done: ack=%0b rdata=%h, expected 1 b2b2b2b2", ack, rdata);
    end
    cyc = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 8'h07, 32'h0BADCAFE, 4'h3);
    tick();
    stb = 1'b0;
    repeat (2) tick(); // in ACCESS, PREADY low
    rst = 1'b1;
    tick();
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || ack !== 1'b0 || stall !== 1'b0 || pstrb !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid: psel=%0b pen=%0b ack=%0b stall=%0b pstrb=%h, expected 0 0 0 0 0",
               psel, penable, ack, stall, pstrb);
    end
    rst = 1'b0; cyc = 1'b0;
    tick();
    issue(1'b0, 8'h09, 32'h0, 4'hF);
    sb.push_back('{ack: 1'b1, err: 1'b0, rd: 1'b1, data: 32'h0F0F0F0F});
    tick();
    stb = 1'b0;
    checks++;
    if (psel !== 1'b1 || paddr !== 10'h024) begin
      errors++;
      $display("FAIL rst_fresh: psel=%0b paddr=%h, expected 1 024", psel, paddr);
    end
    tick();
    pready = 1'b1; prdata = 32'h0F0F0F0F;
    tick();
    pready = 1'b0;
    cyc = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rst_fresh_pending: got %0d, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_cyc_drop();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
